// File: rtl/lagd_pkg.sv
// LAGD shared definitions: island count, L2 memory map entries
// and the L2 arbiter state encoding.
package lagd_pkg;

    localparam int unsigned NUM_ISING_ISLANDS = 4;

    localparam logic [47:0] L2_MEM_BASE_ADDR = 48'h0000_7800_0000;
    localparam int unsigned L2_MEM_SIZE_B    = 32'h0002_0000;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

    function automatic int unsigned id_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lagd_rr_pick.sv
// Stateless round-robin picker: first set request at or above the
// pointer, wrapping to index 0.
module lagd_rr_pick
    import lagd_pkg::*;
#(
    parameter int NumReq = NUM_ISING_ISLANDS,
    parameter int IdW    = id_width(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdW-1:0]    ptr,
    output logic [NumReq-1:0] onehot,
    output logic [IdW-1:0]    idx,
    output logic              any
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            automatic int j = int'(ptr) + i;
            if (j >= NumReq) j = j - NumReq;
            if (!any && req[j]) begin
                any       = 1'b1;
                idx       = IdW'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lagd_l2_arbiter.sv
// L2 port arbiter for the Ising islands: round-robin with beat locking,
// fixed-latency read response routing and response error detection.
module lagd_l2_arbiter
    import lagd_pkg::*;
#(
    parameter int NumReq       = NUM_ISING_ISLANDS,
    parameter int AddrWidth    = 48,
    parameter int DataWidth    = 64,
    parameter int RdLatency    = 1,
    parameter int MaxLockBeats = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0]               req_i,
    input  logic [NumReq-1:0]               req_lock_i,
    input  logic [NumReq-1:0]               req_we_i,
    input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
    input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
    input  logic [NumReq*(DataWidth/8)-1:0] req_be_i,
    output logic [NumReq-1:0]               req_gnt_o,
    output logic [NumReq-1:0]               rsp_valid_o,
    output logic [DataWidth-1:0]            rsp_rdata_o,
    output logic                            mem_req_o,
    output logic                            mem_we_o,
    output logic [AddrWidth-1:0]            mem_addr_o,
    output logic [DataWidth-1:0]            mem_wdata_o,
    output logic [DataWidth/8-1:0]          mem_be_o,
    input  logic                            mem_gnt_i,
    input  logic                            mem_rvalid_i,
    input  logic [DataWidth-1:0]            mem_rdata_i,
    output logic                            err_o
);

    localparam int IdW  = id_width(NumReq);
    localparam int BeW  = DataWidth / 8;
    localparam int CntW = $clog2(MaxLockBeats + 1);

    localparam logic [CntW-1:0] CntLast = CntW'(MaxLockBeats - 1);
    localparam logic [IdW-1:0]  IdLast  = IdW'(NumReq - 1);

    // ghost marks slots that may hold reads discarded by reset
    typedef struct packed {
        logic           valid;
        logic           ghost;
        logic [IdW-1:0] id;
    } slot_t;

    arb_state_e state_q, state_d;

    logic [IdW-1:0]    owner_q, owner_d;
    logic [IdW-1:0]    ptr_q, ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdW-1:0]    sel, pick_idx;
    logic [NumReq-1:0] pick_oh;
    logic              pick_any, hold, beat;

    slot_t [RdLatency-1:0] slot_q;
    slot_t                 last;

    lagd_rr_pick #(
        .NumReq (NumReq),
        .IdW    (IdW)
    ) u_pick (
        .req    (req_i),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign hold = (state_q == LOCKED) && req_i[owner_q];
    assign sel  = hold ? owner_q : pick_idx;
    assign beat = mem_req_o && mem_gnt_i;

    assign mem_req_o   = !rst_i && pick_any;
    assign mem_we_o    = req_we_i[sel];
    assign mem_addr_o  = req_addr_i[int'(sel)*AddrWidth +: AddrWidth];
    assign mem_wdata_o = req_wdata_i[int'(sel)*DataWidth +: DataWidth];
    assign mem_be_o    = req_be_i[int'(sel)*BeW +: BeW];

    assign req_gnt_o = !beat ? '0
                     : hold  ? (NumReq'(1) << owner_q)
                     : pick_oh;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (state_q == LOCKED && !req_i[owner_q]) begin
            state_d = IDLE;
        end
        if (beat) begin
            ptr_d = (sel == IdLast) ? '0 : sel + 1'b1;
            if (hold) begin
                // cnt counts beats after the one that took the lock
                cnt_d = cnt_q + 1'b1;
                if (!req_lock_i[sel] || cnt_d >= CntLast) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end else if (req_lock_i[sel] && MaxLockBeats > 1) begin
                state_d = LOCKED;
                owner_d = sel;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign last = slot_q[RdLatency-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RdLatency; i++) begin
                slot_q[i] <= '{valid: 1'b0, ghost: 1'b1, id: '0};
            end
            err_o <= 1'b0;
        end else begin
            slot_q[0] <= '{valid: beat && !mem_we_o, ghost: 1'b0, id: sel};
            for (int i = 1; i < RdLatency; i++) begin
                slot_q[i] <= slot_q[i-1];
            end
            err_o <= !last.ghost && (last.valid != mem_rvalid_i);
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (!rst_i && last.valid && mem_rvalid_i) begin
            rsp_valid_o[last.id] = 1'b1;
        end
    end

    assign rsp_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_lagd_l2_arbiter.sv
// Directed and random bench for lagd_l2_arbiter against a
// transaction-level model of arbitration, locking and read returns.
module tb_lagd_l2_arbiter;

    localparam int N   = 4;
    localparam int AW  = 48;
    localparam int DW  = 64;
    localparam int BW  = DW / 8;
    localparam int LAT = 2;
    localparam int MLB = 16;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]  req, lock, we;
    logic [AW-1:0] addr  [N];
    logic [DW-1:0] wdata [N];
    logic [BW-1:0] be    [N];
    logic [N*AW-1:0] addr_f;
    logic [N*DW-1:0] wdata_f;
    logic [N*BW-1:0] be_f;

    logic [N-1:0]  gnt, rsp_v;
    logic [DW-1:0] rsp_d, mwdata, mrd;
    logic [AW-1:0] maddr;
    logic [BW-1:0] mbe;
    logic          mreq, mwe, mgnt, mrv, err;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign addr_f[g*AW +: AW]  = addr[g];
        assign wdata_f[g*DW +: DW] = wdata[g];
        assign be_f[g*BW +: BW]    = be[g];
    end

    always #5 clk = ~clk;

    lagd_l2_arbiter #(
        .NumReq       (N),
        .AddrWidth    (AW),
        .DataWidth    (DW),
        .RdLatency    (LAT),
        .MaxLockBeats (MLB)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .req_lock_i   (lock),
        .req_we_i     (we),
        .req_addr_i   (addr_f),
        .req_wdata_i  (wdata_f),
        .req_be_i     (be_f),
        .req_gnt_o    (gnt),
        .rsp_valid_o  (rsp_v),
        .rsp_rdata_o  (rsp_d),
        .mem_req_o    (mreq),
        .mem_we_o     (mwe),
        .mem_addr_o   (maddr),
        .mem_wdata_o  (mwdata),
        .mem_be_o     (mbe),
        .mem_gnt_i    (mgnt),
        .mem_rvalid_i (mrv),
        .mem_rdata_i  (mrd),
        .err_o        (err)
    );

    // reference model state
    int ptr, owner, lbeats, cyc, last_rst;
    bit trk_v [8];
    int trk_id [8];
    bit mem_v [8];
    logic [DW-1:0] mem_d [8];
    bit exp_err, err_known;
    logic [DW-1:0] next_rd;
    bit next_rd_set, drop_f, spur_f;
    int glog [$];
    logic [N-1:0]  obs_rsp [int];
    logic [DW-1:0] obs_d   [int];
    logic          obs_err [int];
    int checks, errors;

    int rr_exp [5] = '{0, 1, 2, 3, 0};
    int lk_exp [6] = '{2, 2, 2, 2, 2, 3};

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        if (owner >= 0 && req[owner]) return owner;
        for (int i = 0; i < N; i++) begin
            if (req[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic int gidx(logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            addr[i]  = AW'({$urandom, $urandom});
            wdata[i] = {$urandom, $urandom};
            be[i]    = BW'($urandom);
        end
    endtask

    task automatic tick();
        int due, s, slot;
        logic [N-1:0] e_gnt, e_rsp;
        logic e_req;
        due = cyc % 8;
        mrv = mem_v[due];
        if (drop_f && mem_v[due]) mrv = 1'b0;
        if (spur_f && !mem_v[due]) mrv = 1'b1;
        mrd = mem_v[due] ? mem_d[due] : {$urandom, $urandom};
        @(negedge clk);
        s     = rst ? -1 : pick();
        e_req = (s >= 0);
        e_gnt = (e_req && mgnt) ? (N'(1) << s) : '0;
        e_rsp = (!rst && trk_v[due] && mrv) ? (N'(1) << trk_id[due]) : '0;
        chk("gnt", gnt, e_gnt);
        chk("mem_req", mreq, e_req);
        if (e_req) begin
            chk("mem_addr", maddr, addr[s]);
            chk("mem_we", mwe, we[s]);
            chk("mem_wdata", mwdata, wdata[s]);
            chk("mem_be", mbe, be[s]);
        end
        chk("rsp_valid", rsp_v, e_rsp);
        if (e_rsp != '0) chk("rsp_rdata", rsp_d, mem_d[due]);
        if (err_known) chk("err", err, exp_err);
        glog.push_back(gidx(gnt));
        obs_rsp[cyc] = rsp_v;
        obs_d[cyc]   = rsp_d;
        obs_err[cyc] = err;
        // advance model across the clock edge
        exp_err   = !rst && (cyc > last_rst + 2) && (trk_v[due] != mrv);
        err_known = 1'b1;
        trk_v[due] = 1'b0;
        mem_v[due] = 1'b0;
        if (rst) begin
            ptr = 0;
            owner = -1;
            lbeats = 0;
            for (int i = 0; i < 8; i++) trk_v[i] = 1'b0;
            last_rst = cyc;
        end else begin
            if (owner >= 0 && !req[owner]) owner = -1;
            if (e_req && mgnt) begin
                ptr = (s + 1) % N;
                if (owner == s) begin
                    lbeats++;
                    if (!lock[s] || lbeats >= MLB) owner = -1;
                end else if (lock[s]) begin
                    owner = s;
                    lbeats = 1;
                end
                if (!we[s]) begin
                    slot = (cyc + LAT) % 8;
                    trk_v[slot]  = 1'b1;
                    trk_id[slot] = s;
                    mem_v[slot]  = 1'b1;
                    mem_d[slot]  = next_rd_set ? next_rd : {$urandom, $urandom};
                end
            end
        end
        next_rd_set = 1'b0;
        drop_f = 1'b0;
        spur_f = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int g0, t0;
        checks = 0; errors = 0;
        ptr = 0; owner = -1; lbeats = 0; cyc = 0; last_rst = -100;
        exp_err = 1'b0; err_known = 1'b0;
        next_rd = '0; next_rd_set = 1'b0; drop_f = 1'b0; spur_f = 1'b0;
        for (int i = 0; i < 8; i++) begin
            trk_v[i] = 1'b0; mem_v[i] = 1'b0; trk_id[i] = 0; mem_d[i] = '0;
        end
        rst = 1'b1; req = 4'hF; lock = 4'h0; we = 4'hF; mgnt = 1'b1;
        mrv = 1'b0; mrd = '0;
        rand_fields();
        @(posedge clk);
        #1;
        tick();
        tick();
        rst = 1'b0;

        // plain round robin
        g0 = glog.size();
        repeat (5) begin rand_fields(); tick(); end
        for (int i = 0; i < 5; i++) chk("rr_order", glog[g0+i], rr_exp[i]);

        // requester 2 locks for 5 beats
        tick();
        g0 = glog.size();
        lock = 4'b0100;
        repeat (4) begin rand_fields(); tick(); end
        lock = 4'b0000;
        repeat (2) begin rand_fields(); tick(); end
        for (int i = 0; i < 6; i++) chk("lock5", glog[g0+i], lk_exp[i]);

        // lock held past the beat limit
        req = 4'b1110; lock = 4'b0010;
        g0 = glog.size();
        repeat (20) begin rand_fields(); tick(); end
        for (int i = 0; i < 19; i++) begin
            chk("maxlock", glog[g0+i], (i < 16) ? 1 : (i == 16) ? 2 : (i == 17) ? 3 : 1);
        end
        lock = 4'b0000;

        // stall: no grant, stable selection, then grant to 1
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b0110; mgnt = 1'b0;
        g0 = glog.size();
        repeat (3) tick();
        mgnt = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) chk("stall_nognt", glog[g0+i], -1);
        chk("stall_release", glog[g0+3], 1);

        // back-to-back reads from 0 and 3
        we = 4'h0;
        req = 4'b0001; next_rd = 64'hA5A5_A5A5_A5A5_A5A5; next_rd_set = 1'b1;
        t0 = cyc;
        tick();
        req = 4'b1000; next_rd = 64'h5A5A_5A5A_5A5A_5A5A; next_rd_set = 1'b1;
        tick();
        req = 4'b0000;
        repeat (3) tick();
        chk("rd_early", obs_rsp[t0+1], 4'b0000);
        chk("rd0_valid", obs_rsp[t0+2], 4'b0001);
        chk("rd0_data", obs_d[t0+2], 64'hA5A5_A5A5_A5A5_A5A5);
        chk("rd3_valid", obs_rsp[t0+3], 4'b1000);
        chk("rd3_data", obs_d[t0+3], 64'h5A5A_5A5A_5A5A_5A5A);

        // missing response, then an unexpected one
        req = 4'b0010;
        t0 = cyc;
        tick();
        req = 4'b0000;
        tick();
        drop_f = 1'b1;
        tick();
        repeat (2) tick();
        chk("err_missing", obs_err[t0+3], 1'b1);
        chk("err_missing_pulse", obs_err[t0+4], 1'b0);
        t0 = cyc;
        spur_f = 1'b1;
        tick();
        repeat (2) tick();
        chk("err_spurious_rsp", obs_rsp[t0], 4'b0000);
        chk("err_spurious", obs_err[t0+1], 1'b1);
        chk("err_spurious_pulse", obs_err[t0+2], 1'b0);

        // reset with two reads in flight
        req = 4'b0001;
        t0 = cyc;
        tick();
        req = 4'b0100;
        tick();
        req = 4'b0000; rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        for (int i = 2; i < 5; i++) begin
            chk("rst_flight_rsp", obs_rsp[t0+i], 4'b0000);
            chk("rst_flight_err", obs_err[t0+i+1], 1'b0);
        end
        req = 4'hF; we = 4'hF;
        g0 = glog.size();
        tick();
        chk("rst_ptr", glog[g0], 0);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            rst    = ($urandom_range(0, 99) == 0);
            req    = 4'($urandom) | 4'($urandom);
            lock   = 4'($urandom) | 4'($urandom);
            we     = 4'($urandom);
            mgnt   = ($urandom_range(0, 3) != 0);
            drop_f = ($urandom_range(0, 29) == 0);
            spur_f = ($urandom_range(0, 29) == 0);
            rand_fields();
            tick();
        end
        rst = 1'b0; req = 4'h0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
